// File: rtl/alu_issue_stage_if.sv
// Handshake bundles around the ALU issue stage: request from decode (instr + GPR reads),
// response toward EX (operands, aluop, destination, illegal flag).
interface alu_issue_req_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  modport master (output in_valid, instr, rs_val, rt_val, input in_ready);
  modport slave  (input in_valid, instr, rs_val, rt_val, output in_ready);
endinterface

interface alu_issue_rsp_if #(parameter int DATA_W = 32, parameter int OP_W = 4,
                             parameter int REG_ADDR_W = 5);
  logic                  out_valid;
  logic                  out_ready;
  logic [OP_W-1:0]       aluop;
  logic [DATA_W-1:0]     input1;
  logic [DATA_W-1:0]     input2;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic                  illegal;

  modport master (output out_valid, aluop, input1, input2, wr_addr, illegal, input out_ready);
  modport slave  (input out_valid, aluop, input1, input2, wr_addr, illegal, output out_ready);
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS decode/issue stage producing ALU operands + aluop on a registered valid/ready output.
// Define ALU_ISSUE_SKID_EN for a two-entry skid buffer with a flopped in_ready.
module alu_issue_stage #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_issue_req_if.slave    req,
  alu_issue_rsp_if.master   rsp
);
  localparam logic [OP_W-1:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SRL = 4'd3,
                              A_SLT = 4'd4, A_AND = 4'd5, A_OR  = 4'd6, A_XOR = 4'd7,
                              A_SLTU = 4'd8, A_SRA = 4'd9;

  typedef struct packed {
    logic                  illegal;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [OP_W-1:0]       aluop;
    logic [DATA_W-1:0]     in1;
    logic [DATA_W-1:0]     in2;
  } bundle_t;

  logic [5:0]        op, funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] sext, zext;
  bundle_t           dec;
  logic              bad;
  logic              unused_rs_addr;

  assign op    = req.instr[31:26];
  assign funct = req.instr[5:0];
  assign imm   = req.instr[15:0];
  assign sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign zext  = {{(DATA_W-16){1'b0}}, imm};
  // rs is already resolved to rs_val upstream; the field itself is not needed here
  assign unused_rs_addr = ^req.instr[25:21];

  always_comb begin
    dec         = '0;
    bad         = 1'b0;
    dec.aluop   = A_ADD;
    dec.in1     = req.rs_val;
    dec.in2     = sext;
    dec.wr_addr = req.instr[20:16];
    case (op)
      6'h00: begin
        dec.wr_addr = req.instr[15:11];
        dec.in2     = req.rt_val;
        case (funct)
          6'h20, 6'h21: dec.aluop = A_ADD;
          6'h22, 6'h23: dec.aluop = A_SUB;
          6'h24: dec.aluop = A_AND;
          6'h25: dec.aluop = A_OR;
          6'h26: dec.aluop = A_XOR;
          6'h2A: dec.aluop = A_SLT;
          6'h2B: dec.aluop = A_SLTU;
          6'h00: begin dec.aluop = A_SLL; dec.in1 = DATA_W'(req.instr[10:6]); end
          6'h02: begin dec.aluop = A_SRL; dec.in1 = DATA_W'(req.instr[10:6]); end
          6'h03: begin dec.aluop = A_SRA; dec.in1 = DATA_W'(req.instr[10:6]); end
          6'h04: dec.aluop = A_SLL;
          6'h06: dec.aluop = A_SRL;
          6'h07: dec.aluop = A_SRA;
          default: bad = 1'b1;
        endcase
      end
      6'h08, 6'h09: dec.aluop = A_ADD;
      6'h0A: dec.aluop = A_SLT;
      6'h0B: dec.aluop = A_SLTU;
      6'h0C: begin dec.aluop = A_AND; dec.in2 = zext; end
      6'h0D: begin dec.aluop = A_OR;  dec.in2 = zext; end
      6'h0E: begin dec.aluop = A_XOR; dec.in2 = zext; end
      6'h0F: begin dec.in1 = '0; dec.in2 = {imm, 16'b0}; end
      6'h23: dec.aluop = A_ADD;
      6'h2B: dec.wr_addr = '0;
      6'h04, 6'h05: begin
        dec.aluop   = A_SUB;
        dec.in2     = req.rt_val;
        dec.wr_addr = '0;
      end
      default: bad = 1'b1;
    endcase
    // unencodable instructions still issue, as a harmless zeroed ADD
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  bundle_t out_q;
  logic    out_v;
  logic    acc, out_free;

  assign out_free = !out_v || rsp.out_ready;
  assign acc      = req.in_valid && req.in_ready;

`ifdef ALU_ISSUE_SKID_EN
  bundle_t sk_q;
  logic    sk_v;

  assign req.in_ready = !sk_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      sk_v  <= 1'b0;
      out_q <= '0;
      sk_q  <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
      sk_v  <= 1'b0;
    end else if (out_free) begin
      // skid slot is older than anything arriving, so it drains first
      if (sk_v) begin
        out_q <= sk_q;
        out_v <= 1'b1;
        sk_v  <= 1'b0;
      end else if (acc) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (acc) begin
      sk_q <= dec;
      sk_v <= 1'b1;
    end
  end
`else
  assign req.in_ready = out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (flush) begin
      out_v <= 1'b0;
    end else if (acc) begin
      out_q <= dec;
      out_v <= 1'b1;
    end else if (rsp.out_ready) begin
      out_v <= 1'b0;
    end
  end
`endif

  assign rsp.out_valid = out_v;
  assign rsp.aluop     = out_q.aluop;
  assign rsp.input1    = out_q.in1;
  assign rsp.input2    = out_q.in2;
  assign rsp.wr_addr   = out_q.wr_addr;
  assign rsp.illegal   = out_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected bundles queued on accept, popped on issue,
// plus directed checks for latency, stall hold, flush and reset.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  alu_issue_req_if req();
  alu_issue_rsp_if rsp();

  alu_issue_stage dut (.clk(clk), .rst(rst), .flush(flush), .req(req), .rsp(rsp));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [73:0] sb[$];
  logic        last_acc = 1'b0;
  logic [73:0] exp_a;

  logic [5:0] rfn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h27, 6'h08};
  logic [5:0] iop [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // reference model: {illegal, wr_addr, aluop, input1, input2}
  function automatic logic [73:0] exp_of(logic [31:0] i, logic [31:0] a, logic [31:0] b);
    logic [5:0] op, fn;
    logic [3:0] u;
    logic [4:0] w;
    logic [31:0] x, y;
    logic ok;
    op = i[31:26]; fn = i[5:0];
    ok = 1'b1; u = 4'd0; w = i[20:16]; x = a;
    y = {{16{i[15]}}, i[15:0]};
    if (op == 6'h00) begin
      w = i[15:11]; y = b;
      case (fn)
        6'h20, 6'h21: u = 4'd0;
        6'h22, 6'h23: u = 4'd1;
        6'h24: u = 4'd5;
        6'h25: u = 4'd6;
        6'h26: u = 4'd7;
        6'h2A: u = 4'd4;
        6'h2B: u = 4'd8;
        6'h00: begin u = 4'd2; x = {27'd0, i[10:6]}; end
        6'h02: begin u = 4'd3; x = {27'd0, i[10:6]}; end
        6'h03: begin u = 4'd9; x = {27'd0, i[10:6]}; end
        6'h04: u = 4'd2;
        6'h06: u = 4'd3;
        6'h07: u = 4'd9;
        default: ok = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23: u = 4'd0;
        6'h0A: u = 4'd4;
        6'h0B: u = 4'd8;
        6'h0C: begin u = 4'd5; y = {16'd0, i[15:0]}; end
        6'h0D: begin u = 4'd6; y = {16'd0, i[15:0]}; end
        6'h0E: begin u = 4'd7; y = {16'd0, i[15:0]}; end
        6'h0F: begin x = 32'd0; y = {i[15:0], 16'd0}; end
        6'h2B: w = 5'd0;
        6'h04, 6'h05: begin u = 4'd1; y = b; w = 5'd0; end
        default: ok = 1'b0;
      endcase
    end
    return ok ? {1'b0, w, u, x, y} : {1'b1, 73'd0};
  endfunction

  function automatic logic [73:0] obs();
    return {rsp.illegal, rsp.wr_addr, rsp.aluop, rsp.input1, rsp.input2};
  endfunction

  task automatic chk(string tag, logic [79:0] o, logic [79:0] e);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  // called at the negedge after inputs are set; advances to the next negedge
  task automatic step();
    #1;
    last_acc = req.in_valid && req.in_ready && !rst && !flush;
    if (rst || flush) sb.delete();
    else begin
      if (rsp.out_valid && rsp.out_ready) begin
        if (sb.size() == 0) chk("sb_spurious", 80'(rsp.out_valid), 80'd0);
        else chk("sb", 80'(obs()), 80'(sb.pop_front()));
      end
      if (last_acc) sb.push_back(exp_of(req.instr, req.rs_val, req.rt_val));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [31:0] i, logic [31:0] a, logic [31:0] b);
    req.in_valid = 1'b1; req.instr = i; req.rs_val = a; req.rt_val = b;
  endtask

  function automatic logic [31:0] rnd_instr();
    if ($urandom_range(0, 1) == 0)
      return rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   rfn[$urandom_range(0, 16)]);
    return itype(iop[$urandom_range(0, 13)], 5'($urandom), 5'($urandom), 16'($urandom));
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0;
    req.in_valid = 1'b0; req.instr = '0; req.rs_val = '0; req.rt_val = '0;
    rsp.out_ready = 1'b1;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 80'(rsp.out_valid), 80'd0);
    chk("rst_bundle", 80'(obs()), 80'd0);
    chk("rst_in_ready", 80'(req.in_ready), 80'd1);

    // addu $3,$1,$2: one-cycle latency
    drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7);
    step();
    req.in_valid = 1'b0;
    chk("addu_valid", 80'(rsp.out_valid), 80'd1);
    chk("addu", 80'(obs()), 80'({1'b0, 5'd3, 4'd0, 32'd5, 32'd7}));

    // sra $4,$2,3
    drive(rtype(5'd0, 5'd2, 5'd4, 5'd3, 6'h03), 32'h1234, 32'h8000_0000);
    step();
    req.in_valid = 1'b0;
    chk("sra", 80'(obs()), 80'({1'b0, 5'd4, 4'd9, 32'd3, 32'h8000_0000}));

    // ori then lui back to back
    drive(itype(6'h0D, 5'd0, 5'd5, 16'h8001), 32'd0, 32'd0);
    step();
    chk("ori", 80'(obs()), 80'({1'b0, 5'd5, 4'd6, 32'd0, 32'h0000_8001}));
    drive(itype(6'h0F, 5'd0, 5'd6, 16'h1234), 32'hdead_beef, 32'd0);
    step();
    req.in_valid = 1'b0;
    chk("lui", 80'(obs()), 80'({1'b0, 5'd6, 4'd0, 32'd0, 32'h1234_0000}));
    step();

    // stall: 3 cycles of out_ready=0 with a second instruction waiting
    rsp.out_ready = 1'b0;
    drive(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h26), 32'd11, 32'd22);
    exp_a = {1'b0, 5'd7, 4'd7, 32'd11, 32'd22};
    step();
    drive(itype(6'h0A, 5'd9, 5'd8, 16'hfff0), 32'd3, 32'd0);
`ifdef ALU_ISSUE_SKID_EN
    chk("stall_rdy0", 80'(req.in_ready), 80'd1);
`else
    chk("stall_rdy0", 80'(req.in_ready), 80'd0);
`endif
    chk("stall_hold0", 80'(obs()), 80'(exp_a));
    step();
    if (last_acc) req.in_valid = 1'b0;
    chk("stall_valid1", 80'(rsp.out_valid), 80'd1);
    chk("stall_hold1", 80'(obs()), 80'(exp_a));
    chk("stall_rdy1", 80'(req.in_ready), 80'd0);
    step();
    if (last_acc) req.in_valid = 1'b0;
    chk("stall_hold2", 80'(obs()), 80'(exp_a));
    chk("stall_rdy2", 80'(req.in_ready), 80'd0);
    rsp.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (last_acc) req.in_valid = 1'b0;
    end
    chk("stall_drained", 80'(sb.size()), 80'd0);
    chk("stall_inval", 80'(req.in_valid), 80'd0);

    // flush while stalled with entries held
    rsp.out_ready = 1'b0;
    drive(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h20), 32'd1, 32'd2);
    step();
    drive(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h22), 32'd3, 32'd4);
    step();
    if (last_acc) drive(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h24), 32'd5, 32'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; req.in_valid = 1'b0; rsp.out_ready = 1'b1;
    chk("flush_valid", 80'(rsp.out_valid), 80'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("flush_quiet", 80'(rsp.out_valid), 80'd0);
    end

    // nor is not encodable
    drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'hff, 32'hff);
    step();
    req.in_valid = 1'b0;
    chk("nor_valid", 80'(rsp.out_valid), 80'd1);
    chk("nor", 80'(obs()), 80'({1'b1, 73'd0}));
    step();

    // reset in the middle of a stall
    rsp.out_ready = 1'b0;
    drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd9, 32'd9);
    step();
    drive(itype(6'h08, 5'd1, 5'd4, 16'd1), 32'd9, 32'd0);
    step();
    rst = 1'b1; req.in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 80'(rsp.out_valid), 80'd0);
    chk("rst_mid_bundle", 80'(obs()), 80'd0);
    chk("rst_mid_rdy", 80'(req.in_ready), 80'd1);
    rsp.out_ready = 1'b1;
    step();
    chk("rst_mid_quiet", 80'(rsp.out_valid), 80'd0);

    // random traffic with random backpressure
    last_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rsp.out_ready = ($urandom_range(0, 3) != 0);
      if (!req.in_valid || last_acc) begin
        req.in_valid = ($urandom_range(0, 3) != 0);
        req.instr = rnd_instr(); req.rs_val = $urandom; req.rt_val = $urandom;
      end
      step();
    end
    if (last_acc) req.in_valid = 1'b0;
    rsp.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (last_acc) req.in_valid = 1'b0;
    end
    chk("rand_drained", 80'(sb.size()), 80'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
